// File: rtl/data_mem_mmio.sv
// Data memory with MMIO block: word RAM, 4-entry output FIFO,
// free-running cycle counter and sticky error/overflow flags.
module data_mem_mmio #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err
);

  localparam int PW = 2;
  localparam int CW = 3;

  logic [31:0]   ram_q  [2**ADDR_W];
  logic [31:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rp_q, rp_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   cyc_q, cyc_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  logic              is_ram, is_mmio, mapped, misal;
  logic              access, both, wr_ok;
  logic [1:0]        rsel;
  logic [ADDR_W-1:0] idx;
  logic              ram_we, out_we, st_we, cyc_we, clr_we;
  logic              rd_ok, rd_ram, rd_st, rd_cyc;
  logic              err_set, ovf_set;
  logic              empty, full, push, pop;
  logic [31:0]       status;

  assign is_ram  = Addr[31:28] == 4'h0;
  assign is_mmio = Addr[31:4] == 28'hFFFF000;
  assign mapped  = is_ram | is_mmio;
  assign misal   = |Addr[1:0];
  assign rsel    = Addr[3:2];
  assign idx     = Addr[ADDR_W+1:2];
  assign access  = MemRead | MemWrite;
  assign both    = MemRead & MemWrite;

  // A combined read+write performs only the read.
  assign wr_ok  = MemWrite & ~MemRead & ~misal;
  assign ram_we = wr_ok & is_ram;
  assign out_we = wr_ok & is_mmio & (rsel == 2'd0);
  assign st_we  = wr_ok & is_mmio & (rsel == 2'd1);
  assign cyc_we = wr_ok & is_mmio & (rsel == 2'd2);
  assign clr_we = wr_ok & is_mmio & (rsel == 2'd3);

  assign rd_ok  = MemRead & ~misal;
  assign rd_ram = rd_ok & is_ram;
  assign rd_st  = rd_ok & is_mmio & (rsel == 2'd1);
  assign rd_cyc = rd_ok & is_mmio & (rsel == 2'd2);

  assign err_set = (access & (misal | ~mapped)) | both | st_we;

  assign empty = cnt_q == '0;
  assign full  = cnt_q == CW'(FIFO_DEPTH);
  assign pop   = ~empty & out_ready;
  assign push  = out_we & (~full | pop);
  assign ovf_set = out_we & ~push;

  assign status = {25'b0, err_q, ovf_q, cnt_q, full, empty};

  always_comb begin
    Dout = '0;
    unique case (1'b1)
      rd_ram:  Dout = ram_q[idx];
      rd_st:   Dout = status;
      rd_cyc:  Dout = cyc_q;
      default: Dout = '0;
    endcase
  end

  always_comb begin
    rp_d  = rp_q + PW'(pop);
    wp_d  = wp_q + PW'(push);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    cyc_d = cyc_we ? Din : cyc_q + 32'd1;
    ovf_d = clr_we ? 1'b0 : (ovf_q | ovf_set);
    err_d = clr_we ? 1'b0 : (err_q | err_set);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rp_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
      cyc_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rp_q  <= rp_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      cyc_q <= cyc_d;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  // Storage is not reset; writes are dropped while reset is held.
  always_ff @(posedge clock) begin
    if (ram_we && !reset) ram_q[idx] <= Din;
    if (push && !reset) fifo_q[wp_q] <= Din;
  end

  assign out_data  = empty ? '0 : fifo_q[rp_q];
  assign out_valid = ~empty;
  assign err       = err_q;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: RAM, MMIO regs,
// FIFO ordering/overflow, cycle counter and async reset.
module tb_data_mem_mmio;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] fm[$];
  logic [31:0] e;

  localparam logic [31:0] A_OUT = 32'hFFFF0000;
  localparam logic [31:0] A_ST  = 32'hFFFF0004;
  localparam logic [31:0] A_CYC = 32'hFFFF0008;
  localparam logic [31:0] A_CLR = 32'hFFFF000C;

  data_mem_mmio #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .Din(Din), .Dout(Dout),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .err(err)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    MemRead = rd; MemWrite = wr; Addr = a; Din = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (out_data !== 32'h0) begin
      failures++; $display("FAIL rst_data got=%h exp=0", out_data);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL rst_err got=%b exp=0", err);
    end
    checks++;
    if (Dout !== 32'h0) begin
      failures++; $display("FAIL rst_dout got=%h exp=0", Dout);
    end
    exp_q.push_back(32'h1);
    drive(1, 0, A_ST, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL rst_status got=%h exp=%h", Dout, e);
    end
    #1 reset = 1'b0;
    drive(0, 0, 0, 0);
  endtask

  task automatic test_ram();
    drive(0, 1, 32'h0, 32'hA5A5A5A5); tick();
    drive(0, 1, 32'h10, 32'h11111111); tick();
    drive(0, 1, 32'h10, 32'hDEADBEEF);
    checks++;
    if (Dout !== 32'h0) begin
      failures++; $display("FAIL ram_noread got=%h exp=0", Dout);
    end
    tick();
    exp_q.push_back(32'hDEADBEEF);
    drive(1, 0, 32'h10, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL ram_rd got=%h exp=%h", Dout, e);
    end
    exp_q.push_back(32'hDEADBEEF);
    drive(1, 0, 32'h0F000010, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL ram_alias got=%h exp=%h", Dout, e);
    end
    exp_q.push_back(32'hDEADBEEF);
    drive(1, 1, 32'h10, 32'h55);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL rw_old got=%h exp=%h", Dout, e);
    end
    tick();
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL rw_err got=%b exp=1", err);
    end
    exp_q.push_back(32'hDEADBEEF);
    drive(1, 0, 32'h10, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL rw_nowrite got=%h exp=%h", Dout, e);
    end
    drive(0, 1, A_CLR, 0); tick();
    drive(0, 0, 0, 0);
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL clr_err got=%b exp=0", err);
    end
  endtask

  task automatic test_errors();
    exp_q.push_back(32'h0);
    drive(1, 0, 32'h6, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL misal_rd got=%h exp=%h", Dout, e);
    end
    tick();
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL misal_err got=%b exp=1", err);
    end
    drive(0, 1, A_CLR, 0); tick();
    drive(0, 1, 32'h20000000, 32'h12345678); tick();
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL unmap_err got=%b exp=1", err);
    end
    exp_q.push_back(32'hA5A5A5A5);
    drive(1, 0, 32'h0, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL unmap_ram got=%h exp=%h", Dout, e);
    end
    exp_q.push_back(32'h41);
    drive(1, 0, A_ST, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL st_err got=%h exp=%h", Dout, e);
    end
    drive(0, 1, 32'h12, 32'h0); tick();
    exp_q.push_back(32'hDEADBEEF);
    drive(1, 0, 32'h10, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL misal_wr got=%h exp=%h", Dout, e);
    end
    drive(0, 1, A_CLR, 0); tick();
    exp_q.push_back(32'h01);
    drive(1, 0, A_ST, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL st_clr got=%h exp=%h", Dout, e);
    end
    drive(0, 1, A_ST, 32'hFF); tick();
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL st_wr_err got=%b exp=1", err);
    end
    exp_q.push_back(32'h0);
    drive(1, 0, A_OUT, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL out_rd got=%h exp=%h", Dout, e);
    end
    drive(0, 1, A_CLR, 0); tick();
    drive(0, 0, 0, 0);
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    drive(0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      e = fm.pop_front(); checks++;
      if (out_valid !== 1'b1 || out_data !== e) begin
        failures++;
        $display("FAIL drain%0d got=%h/%b exp=%h/1", i, out_data, out_valid, e);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      failures++;
      $display("FAIL drain_empty got=%h/%b exp=0/0", out_data, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin
        exp_q.push_back(32'h12);
        drive(1, 0, A_ST, 0);
        e = exp_q.pop_front(); checks++;
        if (Dout !== e) begin
          failures++; $display("FAIL ovf_full got=%h exp=%h", Dout, e);
        end
      end
      drive(0, 1, A_OUT, 32'(i));
      if (fm.size() < 4) fm.push_back(32'(i));
      tick();
    end
    exp_q.push_back(32'h32);
    drive(1, 0, A_ST, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL ovf_flag got=%h exp=%h", Dout, e);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL ovf_noerr got=%b exp=0", err);
    end
    drive(0, 1, A_CLR, 0); tick();
    exp_q.push_back(32'h12);
    drive(1, 0, A_ST, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL ovf_clr got=%h exp=%h", Dout, e);
    end
    drain(4);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1, A_OUT, 32'(i));
      fm.push_back(32'(i));
      tick();
    end
    out_ready = 1'b1;
    drive(0, 1, A_OUT, 32'd9);
    e = fm.pop_front(); checks++;
    if (out_data !== e) begin
      failures++; $display("FAIL b2b_head got=%h exp=%h", out_data, e);
    end
    fm.push_back(32'd9);
    tick();
    out_ready = 1'b0;
    exp_q.push_back(32'h12);
    drive(1, 0, A_ST, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL b2b_status got=%h exp=%h", Dout, e);
    end
    drain(4);
  endtask

  task automatic test_cycle();
    drive(0, 1, A_CYC, 32'hFFFFFFFE); tick();
    exp_q.push_back(32'hFFFFFFFE);
    exp_q.push_back(32'hFFFFFFFF);
    exp_q.push_back(32'h0);
    drive(1, 0, A_CYC, 0);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front(); checks++;
      if (Dout !== e) begin
        failures++; $display("FAIL cyc%0d got=%h exp=%h", i, Dout, e);
      end
      tick();
    end
    drive(0, 0, 0, 0);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 7; i <= 9; i++) begin
      drive(0, 1, A_OUT, 32'(i)); tick();
    end
    drive(0, 1, A_CYC, 32'd100); tick();
    exp_q.push_back(32'd100);
    drive(1, 0, A_CYC, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL ar_cyc_pre got=%h exp=%h", Dout, e);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL ar_valid_pre got=%b exp=1", out_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      failures++;
      $display("FAIL ar_fifo got=%h/%b exp=0/0", out_data, out_valid);
    end
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL ar_cyc got=%h exp=%h", Dout, e);
    end
    exp_q.push_back(32'h01);
    drive(1, 0, A_ST, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL ar_status got=%h exp=%h", Dout, e);
    end
    tick();
    reset = 1'b0;
    exp_q.push_back(32'hDEADBEEF);
    drive(1, 0, 32'h10, 0);
    e = exp_q.pop_front(); checks++;
    if (Dout !== e) begin
      failures++; $display("FAIL ar_ram got=%h exp=%h", Dout, e);
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_ram();
    test_errors();
    test_overflow();
    test_back_to_back();
    test_cycle();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_mmio.md
DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 Parameter: ADDR_W, 8, log2 of data RAM depth in 32-bit words (256 words).
REQ-002 Parameter: FIFO_DEPTH, 4, output FIFO entries; fixed at 4, count field 3 bits.
REQ-003 Port: clock  input  1  rising-edge clock.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: MemRead  input  1  read request from processor memory stage.
REQ-006 Port: MemWrite  input  1  write request from processor memory stage.
REQ-007 Port: Addr  input  32  byte address.
REQ-008 Port: Din  input  32  write data.
REQ-009 Port: Dout  output  32  read data, combinational, same cycle as MemRead.
REQ-010 Port: out_data  output  32  FIFO head word.
REQ-011 Port: out_valid  output  1  FIFO non-empty.
REQ-012 Port: out_ready  input  1  external consumer accepts head.
REQ-013 Port: err  output  1  sticky access-error flag.

Function
REQ-014 Address decode SHALL be: RAM when Addr[31:28]==4'h0, word index Addr[ADDR_W+1:2], upper bits [27:ADDR_W+2] ignored; MMIO when Addr[31:4]==28'hFFFF000; all else unmapped.
REQ-015 MMIO map SHALL be: 0xFFFF0000 OUT (write pushes FIFO, read returns 0); 0xFFFF0004 STATUS (read-only: bit0 empty, bit1 full, bits4:2 count, bit5 overflow, bit6 err, rest 0); 0xFFFF0008 CYCLE (read counter, write loads); 0xFFFF000C CLEAR (write clears overflow and err, read returns 0).
REQ-016 Dout SHALL be 0 when MemRead=0, when the address is unmapped, or when misaligned.
REQ-017 RAM write SHALL occur at the rising edge with MemWrite=1, aligned mapped RAM address; a same-cycle read of that address returns old data, new data from next cycle.
REQ-018 Misaligned access (Addr[1:0]!=0) with MemRead or MemWrite SHALL be suppressed and set err at the edge.
REQ-019 Unmapped access, or a write to STATUS, SHALL be suppressed and set err.
REQ-020 MemRead=1 and MemWrite=1 together SHALL perform the read, suppress the write, and set err.
REQ-021 FIFO pop SHALL occur at the edge when out_valid=1 and out_ready=1; out_data SHALL be the oldest entry, 0 when empty.
REQ-022 OUT write SHALL push Din if count<4, or if count==4 and a pop occurs the same edge; otherwise Din is dropped, count unchanged, overflow set.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-024 Read/write pointers SHALL be 2-bit and wrap 3->0.
REQ-025 CYCLE SHALL increment by 1 every clock, wrapping 0xFFFFFFFF->0; a CYCLE write loads Din at that edge (increment resumes next cycle); a CYCLE read returns the pre-edge value.
REQ-026 A CLEAR write SHALL take priority over any error or overflow set in the same cycle (flags read 0 afterwards), except the error caused by the CLEAR access itself, which cannot occur for an aligned CLEAR write.
REQ-027 err and overflow SHALL stay set until CLEAR or reset.

Reset
REQ-028 Reset SHALL asynchronously force FIFO empty (pointers 0, count 0), CYCLE=0, overflow=0, err=0; hence out_valid=0, out_data=0, and Dout=0 when MemRead=0.
REQ-029 RAM contents SHALL NOT be reset; reset asserted mid-operation SHALL discard that cycle's write, push, and pop.

Verification
REQ-030 Write 0xDEADBEEF to 0x00000010, read 0x00000010 next cycle -> Dout=0xDEADBEEF; same-cycle read during the write -> old value.
REQ-031 Five OUT writes 1..5 with out_ready=0 -> STATUS=0x12 (full, count 4), overflow set, STATUS then 0x32; raise out_ready -> out_data 1,2,3,4 on successive cycles, then out_valid=0.
REQ-032 FIFO full, OUT write 9 with out_ready=1 -> pop 1, push 9, count stays 4, no overflow; drain order 2,3,4,9.
REQ-033 Write 0xFFFFFFFE to CYCLE -> reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0 on following cycles.
REQ-034 Read 0x00000006, then write 0x20000000 -> err=1, Dout=0, RAM unchanged; CLEAR write -> STATUS bit6=0.
REQ-035 Assert reset with 3 FIFO entries and CYCLE=100 -> out_valid=0, STATUS=0x01, CYCLE=0 immediately, without waiting for a clock edge.
